pipe_stage_buf: RTL

- Parametrised pipeline-stage register. Successor to the fixed-width stage registers with freeze (hold) and flush.
- Adds a valid/ready handshake and an optional 2-entry skid slot, so stalls no longer need a global combinational freeze.
- Carries the payload plus an exception code and a branch-delay (BD) flag.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W) of the MIPS core.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 38 +++
 rtl/pipe_stage_buf.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline-stage buffer and its storage slot.
// Holds the occupancy state enum and the default-width entry layout with its bubble value.
package pipe_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int EXC_W_DEF    = 5;
    localparam int EXC_NONE_DEF = 31;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [EXC_W_DEF-1:0]  exc;
        logic                  bd;
    } pipe_entry_t;

    localparam pipe_entry_t PIPE_BUBBLE = '{
        data: '0,
        exc:  5'(EXC_NONE_DEF),
        bd:   1'b0
    };

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: load, clear-to-bubble or hold.
// Latency: load visible one cycle later. Backpressure: none, the owner decides when to load.
// Clear wins over load so a kill always leaves a clean bubble.
module pipe_slot #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = BUBBLE;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage register with optional skid entry; PIPE_STAGE_PERF_EN adds stall_cnt.
// Latency: one cycle from input fire to out_*; all outputs come from the head register.
// Backpressure: DEPTH=1 in_ready follows out_ready; DEPTH=2 in_ready is registered (low only when full).
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int EXC_W    = EXC_W_DEF,
    parameter int EXC_NONE = EXC_NONE_DEF,
    parameter int DEPTH    = 2
) (
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic              out_has_exc
);

    localparam logic [EXC_W-1:0] EXC_NONE_V = EXC_NONE[EXC_W-1:0];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } entry_t;

    localparam int     ENTRY_W = $bits(entry_t);
    localparam entry_t BUBBLE  = '{data: '0, exc: EXC_NONE_V, bd: 1'b0};
    localparam logic [ENTRY_W-1:0] BUBBLE_V = BUBBLE;

    pipe_state_e state_q;
    pipe_state_e state_d;

    entry_t in_ent;
    entry_t head_q;
    entry_t skid_q;
    entry_t head_din;

    logic head_ld;
    logic head_clr;
    logic skid_ld;
    logic skid_clr;
    logic in_fire;
    logic out_fire;

    assign in_ent   = '{data: in_data, exc: in_exc, bd: in_bd};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Flush behaves like reset for state and data; a same-cycle output fire is
    // still consumed downstream, so simply dropping everything is correct.
    always_comb begin
        state_d  = state_q;
        head_ld  = 1'b0;
        head_clr = 1'b0;
        head_din = in_ent;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        head_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_ld = 1'b1;
                    end else if (in_fire && (DEPTH == 2)) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        head_clr = 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d  = ONE;
                        head_ld  = 1'b1;
                        head_din = skid_q;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    head_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .W      (ENTRY_W),
        .BUBBLE (BUBBLE_V)
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_ld),
        .clear (head_clr),
        .d     (head_din),
        .q     (head_q)
    );

    generate
        if (DEPTH == 2) begin : g_skid
            logic in_rdy_q;
            logic in_rdy_d;

            pipe_slot #(
                .W      (ENTRY_W),
                .BUBBLE (BUBBLE_V)
            ) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_ld),
                .clear (skid_clr),
                .d     (in_ent),
                .q     (skid_q)
            );

            // Registered ready keeps out_ready off the upstream timing path.
            assign in_rdy_d = (state_d != TWO);

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_rdy_q <= 1'b1;
                end else begin
                    in_rdy_q <= in_rdy_d;
                end
            end

            assign in_ready = in_rdy_q;
        end else begin : g_noskid
            assign skid_q   = BUBBLE;
            assign in_ready = (state_q == EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid   = (state_q != EMPTY);
    assign out_data    = head_q.data;
    assign out_exc     = head_q.exc;
    assign out_bd      = head_q.bd;
    assign out_has_exc = out_valid & (head_q.exc != EXC_NONE_V);

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
